// File: rtl/decoder_pkg.sv
// Shared opcode constants, instruction format enum and immediate width for the RV32I decoder.
package decoder_pkg;

  localparam int unsigned IMM_W = 21;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e fmt_of(logic [6:0] op);
    case (op)
      OP_R:                                 return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  return FMT_I;
      OP_STORE:                             return FMT_S;
      OP_BRANCH:                            return FMT_B;
      OP_LUI, OP_AUIPC:                     return FMT_U;
      OP_JAL:                               return FMT_J;
      default:                              return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/decoder_imm_gen.sv
// Combinational immediate builder: assembles and sign-extends the 21-bit immediate per format.
module decoder_imm_gen
  import decoder_pkg::*;
(
  input  logic [31:7]      instr_i,
  input  fmt_e             fmt_i,
  output logic [IMM_W-1:0] imm_o
);

  logic sgn;
  assign sgn = instr_i[31];

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      FMT_I: imm_o = {{9{sgn}}, instr_i[31:20]};
      FMT_S: imm_o = {{9{sgn}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{8{sgn}}, sgn, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: imm_o = {sgn, instr_i[31:12]};
      FMT_J: imm_o = {sgn, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decoder.sv
// RV32I field decoder with registered outputs (latency 1).
// Optional DECODER_ILLEGAL_EN adds a registered illegal-opcode flag.
module decoder
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  output logic [2:0]       func3,
  output logic [6:0]       func7,
  output logic [6:0]       opcode,
  output logic [4:0]       r1,
  output logic [4:0]       r2,
  output logic [4:0]       rd,
`ifdef DECODER_ILLEGAL_EN
  output logic             illegal,
`endif
  output logic [IMM_W-1:0] imm
);

  fmt_e             fmt;
  logic [IMM_W-1:0] imm_d, imm_q;
  logic [2:0]       func3_d, func3_q;
  logic [6:0]       func7_d, func7_q;
  logic [6:0]       opcode_q;
  logic [4:0]       r1_d, r1_q;
  logic [4:0]       r2_d, r2_q;
  logic [4:0]       rd_d, rd_q;

  assign fmt = fmt_of(instruction[6:0]);

  decoder_imm_gen u_imm_gen (
    .instr_i (instruction[31:7]),
    .fmt_i   (fmt),
    .imm_o   (imm_d)
  );

  // Fields a format does not use are forced to zero.
  always_comb begin
    func3_d = '0;
    func7_d = '0;
    r1_d    = '0;
    r2_d    = '0;
    rd_d    = '0;
    case (fmt)
      FMT_R: begin
        rd_d    = instruction[11:7];
        func3_d = instruction[14:12];
        r1_d    = instruction[19:15];
        r2_d    = instruction[24:20];
        func7_d = instruction[31:25];
      end
      FMT_I: begin
        rd_d    = instruction[11:7];
        func3_d = instruction[14:12];
        r1_d    = instruction[19:15];
      end
      FMT_S, FMT_B: begin
        func3_d = instruction[14:12];
        r1_d    = instruction[19:15];
        r2_d    = instruction[24:20];
      end
      FMT_U, FMT_J: rd_d = instruction[11:7];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      func3_q  <= '0;
      func7_q  <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
    end else begin
      opcode_q <= instruction[6:0];
      func3_q  <= func3_d;
      func7_q  <= func7_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
    end
  end

`ifdef DECODER_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= (fmt == FMT_BAD);
    end
  end

  assign illegal = illegal_q;
`endif

  assign opcode = opcode_q;
  assign func3  = func3_q;
  assign func7  = func7_q;
  assign r1     = r1_q;
  assign r2     = r2_q;
  assign rd     = rd_q;
  assign imm    = imm_q;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus pushes hand-computed expectations, a monitor pops
// and compares one cycle after each issued instruction.
module tb_decoder;

  typedef struct packed {
    logic        ill;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic [20:0] imm;
  } out_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [6:0]  opcode;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic [4:0]  rd;
  logic [20:0] imm;
  logic        illegal_w;

  int errors = 0;
  int checks = 0;

  sb_t  sb_q[$];
  logic issue;
  logic issue_q;

  decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .func3       (func3),
    .func7       (func7),
    .opcode      (opcode),
    .r1          (r1),
    .r2          (r2),
    .rd          (rd),
`ifdef DECODER_ILLEGAL_EN
    .illegal     (illegal_w),
`endif
    .imm         (imm)
  );

`ifndef DECODER_ILLEGAL_EN
  assign illegal_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t actual();
    out_t a;
    a.ill    = illegal_w;
    a.opcode = opcode;
    a.func3  = func3;
    a.func7  = func7;
    a.r1     = r1;
    a.r2     = r2;
    a.rd     = rd;
    a.imm    = imm;
    return a;
  endfunction

  function automatic out_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [4:0] a,
                              logic [4:0] b, logic [4:0] d, logic [20:0] im, logic il);
    out_t o;
    o.ill = il; o.opcode = op; o.func3 = f3; o.func7 = f7;
    o.r1 = a; o.r2 = b; o.rd = d; o.imm = im;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ill=%0b op=%h f3=%h f7=%h r1=%0d r2=%0d rd=%0d imm=%h, expected ill=%0b op=%h f3=%h f7=%h r1=%0d r2=%0d rd=%0d imm=%h",
               name, act.ill, act.opcode, act.func3, act.func7, act.r1, act.r2, act.rd, act.imm,
               exp.ill, exp.opcode, exp.func3, exp.func7, exp.r1, exp.r2, exp.rd, exp.imm);
    end
  endtask

  // Marks which clock edges registered an issued instruction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue_q <= 1'b0;
    else        issue_q <= issue;
  end

  always @(negedge clk) begin
    if (issue_q) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output presented with empty queue");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check(e.name, actual(), e.exp);
      end
    end
  end

  task automatic send(input string name, input logic [31:0] ins, input out_t exp);
    sb_t e;
    @(negedge clk);
    instruction = ins;
    issue       = 1'b1;
    e.name      = name;
    e.exp       = exp;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    issue = 1'b0;
  endtask

  out_t zero;

  initial begin
    zero        = '0;
    issue       = 1'b0;
    rst_n       = 1'b0;
    instruction = 32'h002080B3;
    #3;
    check("reset_async", actual(), zero);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", actual(), zero);
    @(negedge clk);
    rst_n = 1'b1;

    send("add",      32'h002080B3, mk(7'b0110011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd1, 21'h0, 1'b0));
    send("sub",      32'h402081B3, mk(7'b0110011, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 21'h0, 1'b0));
    send("beq_2048", 32'h002080E3, mk(7'b1100011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 21'h000800, 1'b0));
    send("beq_m4",   32'hFE000EE3, mk(7'b1100011, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 21'h1FFFFC, 1'b0));
    // Bit 19 of the word lands in imm[19] under the J layout: 0x80000.
    send("jal",      32'h000800EF, mk(7'b1101111, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 21'h080000, 1'b0));
    send("jal_neg",  32'hFFFFF06F, mk(7'b1101111, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 21'h1FFFFE, 1'b0));
    send("addi_m1",  32'hFFF00293, mk(7'b0010011, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 21'h1FFFFF, 1'b0));
    send("sw_m4",    32'hFE20AE23, mk(7'b0100011, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 21'h1FFFFC, 1'b0));
    send("lw",       32'h00812303, mk(7'b0000011, 3'd2, 7'h00, 5'd2, 5'd0, 5'd6, 21'h000008, 1'b0));
    send("jalr",     32'h000080E7, mk(7'b1100111, 3'd0, 7'h00, 5'd1, 5'd0, 5'd1, 21'h0, 1'b0));
    send("lui",      32'h123450B7, mk(7'b0110111, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 21'h012345, 1'b0));
    send("auipc",    32'h80000297, mk(7'b0010111, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 21'h180000, 1'b0));
    send("ecall",    32'h00000073, mk(7'b1110011, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 21'h0, 1'b0));
`ifdef DECODER_ILLEGAL_EN
    send("bad_op",   32'hFFFFFFFF, mk(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 21'h0, 1'b1));
`else
    send("bad_op",   32'hFFFFFFFF, mk(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 21'h0, 1'b0));
`endif
    send("after_bad", 32'h002080B3, mk(7'b0110011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd1, 21'h0, 1'b0));
    idle();

    // Mid-stream reset: registered decode must vanish immediately.
    send("pre_reset", 32'hFFF00293, mk(7'b0010011, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 21'h1FFFFF, 1'b0));
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", actual(), zero);
    @(negedge clk);
    rst_n = 1'b1;
    send("post_reset", 32'hFE20AE23, mk(7'b0100011, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 21'h1FFFFC, 1'b0));
    idle();

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
